// File: rtl/cmprs_tile_buf_writer_if.sv
// rtl/cmprs_tile_buf_writer_if.sv - tile-transfer and page-handshake bundle for the buffer writer
//
// Groups the sequencer request/grant/done handshake, the tile coordinates and
// write page, and the page-level handshake toward the buffer-reader side.
//   master : the buffer writer (drives request, coordinates, page pulses)
//   slave  : the sequencer / reader side (drives grant, done, next_page)
interface cmprs_tile_buf_writer_if #(
    parameter int TILE_W = 13
);
    logic              xfer_want;
    logic              xfer_grant;
    logic              xfer_done;
    logic [TILE_W-1:0] tile_x;
    logic [TILE_W-1:0] tile_y;
    logic [1:0]        wr_page;
    logic              xfer_reset_page;
    logic              page_ready;
    logic              next_page;

    modport master (
        output xfer_want,
        input  xfer_grant,
        input  xfer_done,
        output tile_x,
        output tile_y,
        output wr_page,
        output xfer_reset_page,
        output page_ready,
        input  next_page
    );

    modport slave (
        input  xfer_want,
        output xfer_grant,
        output xfer_done,
        input  tile_x,
        input  tile_y,
        input  wr_page,
        input  xfer_reset_page,
        input  page_ready,
        output next_page
    );
endinterface

// File: rtl/cmprs_tile_buf_writer.sv
// rtl/cmprs_tile_buf_writer.sv - producer side of the 4-page compressor macroblock buffer
//
// Sequences one frame of tile transfers into buffer pages, pulses page_ready
// per filled page, and tracks page credits returned by the reader.
// Ports:
//   mclk, mrst_n             clock, asynchronous active-low reset
//   frame_en                 0 aborts to IDLE (counters held)
//   frame_start              pulse, starts a frame when idle
//   n_tiles_row_m1           tiles per row minus 1
//   n_tile_rows_m1           tile rows minus 1
//   xif (master)             sequencer handshake, tile coords, page pulses
//   pages_used               allocated pages 0..4
//   frame_done               pulse after the last tile's page_ready
//   busy                     state != IDLE
//   underflow_err            sticky, next_page seen with no pages allocated
module cmprs_tile_buf_writer #(
    parameter int NUM_PAGES = 4,
    parameter int TILE_W    = 13
) (
    input  logic                    mclk,
    input  logic                    mrst_n,
    input  logic                    frame_en,
    input  logic                    frame_start,
    input  logic [TILE_W-1:0]       n_tiles_row_m1,
    input  logic [TILE_W-1:0]       n_tile_rows_m1,
    cmprs_tile_buf_writer_if.master xif,
    output logic [2:0]              pages_used,
    output logic                    frame_done,
    output logic                    busy,
    output logic                    underflow_err
);
    localparam logic [2:0] PAGES_FULL = 3'(NUM_PAGES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RSTPG,
        S_REQ,
        S_XFER
    } state_t;

    state_t            state;
    logic [TILE_W-1:0] tiles_row_m1;
    logic [TILE_W-1:0] tile_rows_m1;
    logic [TILE_W-1:0] tile_x;
    logic [TILE_W-1:0] tile_y;
    logic [1:0]        wr_page;
    logic              reset_page;
    logic              page_ready;

    logic want;
    logic take_grant;
    logic last_col;
    logic last_tile;

    // Request is withheld while all pages are owned by the reader.
    assign want       = (state == S_REQ) && (pages_used != PAGES_FULL);
    // A grant only counts when it actually moves us into XFER.
    assign take_grant = want && xif.xfer_grant && frame_en;
    assign last_col   = (tile_x == tiles_row_m1);
    assign last_tile  = last_col && (tile_y == tile_rows_m1);

    assign xif.xfer_want       = want;
    assign xif.tile_x          = tile_x;
    assign xif.tile_y          = tile_y;
    assign xif.wr_page         = wr_page;
    assign xif.xfer_reset_page = reset_page;
    assign xif.page_ready      = page_ready;
    assign busy                = (state != S_IDLE);

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            state         <= S_IDLE;
            tiles_row_m1  <= '0;
            tile_rows_m1  <= '0;
            tile_x        <= '0;
            tile_y        <= '0;
            wr_page       <= '0;
            pages_used    <= '0;
            underflow_err <= 1'b0;
            reset_page    <= 1'b0;
            page_ready    <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            reset_page <= 1'b0;
            page_ready <= 1'b0;
            frame_done <= 1'b0;

            // Page credits: allocate on grant, release on next_page; both
            // together cancel out.
            if (xif.next_page && (pages_used == 3'd0))
                underflow_err <= 1'b1;
            if (take_grant && !xif.next_page)
                pages_used <= pages_used + 3'd1;
            else if (!take_grant && xif.next_page && (pages_used != 3'd0))
                pages_used <= pages_used - 3'd1;

            if (!frame_en) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (frame_start) begin
                            tiles_row_m1  <= n_tiles_row_m1;
                            tile_rows_m1  <= n_tile_rows_m1;
                            tile_x        <= '0;
                            tile_y        <= '0;
                            wr_page       <= '0;
                            pages_used    <= '0;
                            underflow_err <= 1'b0;
                            reset_page    <= 1'b1;
                            state         <= S_RSTPG;
                        end
                    end
                    S_RSTPG: begin
                        state <= S_REQ;
                    end
                    S_REQ: begin
                        if (take_grant)
                            state <= S_XFER;
                    end
                    S_XFER: begin
                        if (xif.xfer_done) begin
                            page_ready <= 1'b1;
                            wr_page    <= wr_page + 2'd1;
                            if (last_col) begin
                                tile_x <= '0;
                                tile_y <= tile_y + 1'b1;
                            end else begin
                                tile_x <= tile_x + 1'b1;
                            end
                            if (last_tile) begin
                                frame_done <= 1'b1;
                                state      <= S_IDLE;
                            end else begin
                                state      <= S_REQ;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cmprs_tile_buf_writer.sv
// tb/tb_cmprs_tile_buf_writer.sv - directed self-checking bench for cmprs_tile_buf_writer
module tb_cmprs_tile_buf_writer;
    localparam int TILE_W = 13;

    logic              mclk = 1'b0;
    logic              mrst_n = 1'b0;
    logic              frame_en = 1'b0;
    logic              frame_start = 1'b0;
    logic [TILE_W-1:0] n_tiles_row_m1 = '0;
    logic [TILE_W-1:0] n_tile_rows_m1 = '0;
    logic [2:0]        pages_used;
    logic              frame_done;
    logic              busy;
    logic              underflow_err;

    int total = 0;
    int bad   = 0;

    cmprs_tile_buf_writer_if #(.TILE_W(TILE_W)) xif ();

    cmprs_tile_buf_writer #(.NUM_PAGES(4), .TILE_W(TILE_W)) dut (
        .mclk           (mclk),
        .mrst_n         (mrst_n),
        .frame_en       (frame_en),
        .frame_start    (frame_start),
        .n_tiles_row_m1 (n_tiles_row_m1),
        .n_tile_rows_m1 (n_tile_rows_m1),
        .xif            (xif),
        .pages_used     (pages_used),
        .frame_done     (frame_done),
        .busy           (busy),
        .underflow_err  (underflow_err)
    );

    always #5 mclk = ~mclk;

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        xif.xfer_grant = 1'b0;
        xif.xfer_done  = 1'b0;
        xif.next_page  = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_want",  32'(xif.xfer_want), 0);
        chk("rst_rstpg", 32'(xif.xfer_reset_page), 0);
        chk("rst_prdy",  32'(xif.page_ready), 0);
        chk("rst_used",  32'(pages_used), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_fdone", 32'(frame_done), 0);
        chk("rst_uflow", 32'(underflow_err), 0);
        chk("rst_wpage", 32'(xif.wr_page), 0);
        mrst_n = 1'b1;
        step();

        // 2x2 frame, reader returns each page shortly after page_ready
        frame_en = 1'b1;
        n_tiles_row_m1 = 13'd1;
        n_tile_rows_m1 = 13'd1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("f1_rstpg", 32'(xif.xfer_reset_page), 1);
        chk("f1_busy",  32'(busy), 1);
        chk("f1_want0", 32'(xif.xfer_want), 0);
        step();
        chk("f1_rstpg_off", 32'(xif.xfer_reset_page), 0);
        for (int k = 0; k < 4; k++) begin
            chk("f1_want",  32'(xif.xfer_want), 1);
            chk("f1_tx",    32'(xif.tile_x), 32'(k % 2));
            chk("f1_ty",    32'(xif.tile_y), 32'(k / 2));
            chk("f1_wpage", 32'(xif.wr_page), 32'(k));
            xif.xfer_grant = 1'b1;
            step();
            xif.xfer_grant = 1'b0;
            chk("f1_want_g", 32'(xif.xfer_want), 0);
            chk("f1_used_g", 32'(pages_used), 1);
            step();
            step();
            xif.xfer_done = 1'b1;
            step();
            xif.xfer_done = 1'b0;
            chk("f1_prdy",  32'(xif.page_ready), 1);
            chk("f1_wpn",   32'(xif.wr_page), 32'((k + 1) % 4));
            chk("f1_fdone", 32'(frame_done), (k == 3) ? 1 : 0);
            chk("f1_busyd", 32'(busy), (k == 3) ? 0 : 1);
            chk("f1_wantd", 32'(xif.xfer_want), (k == 3) ? 0 : 1);
            step();
            chk("f1_prdy_off", 32'(xif.page_ready), 0);
            chk("f1_fd_off",   32'(frame_done), 0);
            step();
            xif.next_page = 1'b1;
            step();
            xif.next_page = 1'b0;
            chk("f1_used_n", 32'(pages_used), 0);
        end
        chk("f1_end_ty", 32'(xif.tile_y), 2);
        chk("f1_uflow",  32'(underflow_err), 0);

        // 6x1 frame with no page returns: credit limit stops at 4
        n_tiles_row_m1 = 13'd5;
        n_tile_rows_m1 = 13'd0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("f2_rstpg", 32'(xif.xfer_reset_page), 1);
        step();
        for (int k = 0; k < 4; k++) begin
            chk("f2_want", 32'(xif.xfer_want), 1);
            xif.xfer_grant = 1'b1;
            step();
            xif.xfer_grant = 1'b0;
            chk("f2_used", 32'(pages_used), 32'(k + 1));
            xif.xfer_done = 1'b1;
            step();
            xif.xfer_done = 1'b0;
            chk("f2_prdy",  32'(xif.page_ready), 1);
            chk("f2_tx",    32'(xif.tile_x), 32'(k + 1));
            chk("f2_wpage", 32'(xif.wr_page), 32'((k + 1) % 4));
            chk("f2_wantd", 32'(xif.xfer_want), (k == 3) ? 0 : 1);
        end
        // Grant while not requesting is ignored
        xif.xfer_grant = 1'b1;
        step();
        xif.xfer_grant = 1'b0;
        chk("f2_full_used", 32'(pages_used), 4);
        chk("f2_full_want", 32'(xif.xfer_want), 0);
        chk("f2_full_busy", 32'(busy), 1);
        xif.next_page = 1'b1;
        step();
        xif.next_page = 1'b0;
        chk("f2_np_used", 32'(pages_used), 3);
        chk("f2_np_want", 32'(xif.xfer_want), 1);
        chk("f2_np_tx",   32'(xif.tile_x), 4);

        // Grant and next_page together: occupancy unchanged, into XFER
        xif.xfer_grant = 1'b1;
        xif.next_page  = 1'b1;
        step();
        xif.xfer_grant = 1'b0;
        xif.next_page  = 1'b0;
        chk("gn_used", 32'(pages_used), 3);
        chk("gn_want", 32'(xif.xfer_want), 0);
        chk("gn_busy", 32'(busy), 1);

        // Abort during XFER, then a late xfer_done is ignored
        frame_en = 1'b0;
        step();
        chk("ab_busy", 32'(busy), 0);
        chk("ab_used", 32'(pages_used), 3);
        xif.xfer_done = 1'b1;
        step();
        xif.xfer_done = 1'b0;
        chk("ab_prdy", 32'(xif.page_ready), 0);
        chk("ab_tx",   32'(xif.tile_x), 4);
        chk("ab_want", 32'(xif.xfer_want), 0);

        // Drain in IDLE, then underflow
        xif.next_page = 1'b1;
        step();
        step();
        step();
        chk("dr_used", 32'(pages_used), 0);
        chk("dr_uflow0", 32'(underflow_err), 0);
        step();
        xif.next_page = 1'b0;
        chk("uf_flag", 32'(underflow_err), 1);
        chk("uf_used", 32'(pages_used), 0);
        step();
        chk("uf_sticky", 32'(underflow_err), 1);

        // Restart clears everything
        frame_en = 1'b1;
        n_tiles_row_m1 = 13'd1;
        n_tile_rows_m1 = 13'd1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("rs_rstpg", 32'(xif.xfer_reset_page), 1);
        chk("rs_uflow", 32'(underflow_err), 0);
        chk("rs_used",  32'(pages_used), 0);
        chk("rs_tx",    32'(xif.tile_x), 0);
        chk("rs_ty",    32'(xif.tile_y), 0);
        step();
        // frame_start while busy is ignored
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("bs_rstpg", 32'(xif.xfer_reset_page), 0);
        chk("bs_want",  32'(xif.xfer_want), 1);

        // Async reset mid-XFER with two pages allocated
        xif.xfer_grant = 1'b1;
        step();
        xif.xfer_grant = 1'b0;
        xif.xfer_done = 1'b1;
        step();
        xif.xfer_done = 1'b0;
        chk("ar_wp1", 32'(xif.wr_page), 1);
        xif.xfer_grant = 1'b1;
        step();
        xif.xfer_grant = 1'b0;
        chk("ar_used2", 32'(pages_used), 2);
        #2;
        mrst_n = 1'b0;
        #1;
        chk("ar_used", 32'(pages_used), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_wp",   32'(xif.wr_page), 0);
        chk("ar_tx",   32'(xif.tile_x), 0);
        chk("ar_want", 32'(xif.xfer_want), 0);
        step();
        mrst_n = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("ar_rstpg", 32'(xif.xfer_reset_page), 1);
        chk("ar_busy1", 32'(busy), 1);
        step();
        chk("ar_want1", 32'(xif.xfer_want), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cmprs_tile_buf_writer.md
# cmprs_tile_buf_writer

Producer side of the 4-page compressor macroblock buffer: sequences memory-tile transfers for one frame into buffer pages, announces each filled page with a single-cycle `page_ready`, and reclaims pages on `next_page` pulses from the compressor-side reader. Runs entirely in the `mclk` domain, between the DDR3 channel sequencer (request/grant/done) and the buffer-reader clock-crossing logic. Enforces the 4-page credit limit so a page is never overwritten before the reader has released it.

## Interface
- `NUM_PAGES` — 4 — buffer pages; occupancy counter is 3 bits wide.
- `TILE_W` — 13 — width of tile column/row counters.

- `mclk` in 1 — single clock; all logic on posedge.
- `mrst_n` in 1 — asynchronous, active-low reset.
- `frame_en` in 1 — 0: synchronous abort to IDLE.
- `frame_start` in 1 — pulse; latches frame parameters, accepted in IDLE only.
- `n_tiles_row_m1` in TILE_W — tiles per row minus 1.
- `n_tile_rows_m1` in TILE_W — tile rows minus 1.
- `xfer_want` out 1 — request transfer of tile (`tile_x`,`tile_y`).
- `xfer_grant` in 1 — pulse; sequencer accepted the request.
- `xfer_done` in 1 — pulse; tile fully written to page `wr_page`.
- `tile_x`, `tile_y` out TILE_W — coordinates of the current tile.
- `wr_page` out 2 — page being or next to be written.
- `xfer_reset_page` out 1 — pulse; resets the reader page pointers.
- `page_ready` out 1 — pulse; one page completed.
- `next_page` in 1 — pulse; reader freed its oldest page.
- `pages_used` out 3 — allocated pages, 0..4.
- `frame_done` out 1 — pulse after the last tile's `page_ready`.
- `busy` out 1 — state != IDLE.
- `underflow_err` out 1 — sticky; `next_page` received with `pages_used`==0.

## Operation
- States: IDLE, RSTPG, REQ, XFER.
- IDLE, `frame_start` and `frame_en`: latch the `_m1` values; clear `tile_x`, `tile_y`, `wr_page`, `pages_used`, `underflow_err`; go to RSTPG.
- RSTPG: `xfer_reset_page`=1 for exactly this cycle, then go to REQ.
- REQ: `xfer_want` = (state==REQ) && (`pages_used` != 4), combinational from registers. A `xfer_grant` while `xfer_want`=1 takes the transition to XFER and increments `pages_used`. A grant while `xfer_want`=0 is ignored.
- XFER: on `xfer_done`, next cycle:
  - `page_ready`=1;
  - `wr_page`++ mod 4;
  - tile advance: `tile_x`++, or on `tile_x`==`n_tiles_row_m1` wrap to 0 and `tile_y`++;
  - if the tile was last (x and y both at their `_m1` values), `frame_done`=1 and go to IDLE; otherwise go to REQ.
- One transfer is in flight at most.
- `next_page` with `pages_used`>0: decrement. With `pages_used`==0: no change, set `underflow_err`. `next_page` is honoured in every state, including IDLE, so the reader can drain after `frame_done`.
- Grant and `next_page` in the same cycle: `pages_used` unchanged.
- `frame_en`=0 in any state: go to IDLE next cycle; `xfer_want` drops with the state. `pages_used`, `wr_page` and the tile counters are held. An `xfer_done` arriving in IDLE is ignored: no `page_ready`.
- `frame_start` while `busy`=1: ignored.
- `mrst_n` low: all registers 0 and state IDLE immediately, mid-transfer included.

## Timing
- Reset values: every output 0, state IDLE.
- `frame_start` at cycle t:
  - `xfer_reset_page` at t+1;
  - `busy` at t+1;
  - `xfer_want` at t+2, since `pages_used`=0 at that point.
- Grant sampled at g: `xfer_want`=0 and `pages_used`+1 at g+1.
- `xfer_done` at d:
  - `page_ready` at d+1;
  - `wr_page`, `tile_x` and `tile_y` updated at d+1;
  - `xfer_want` again at d+1 if `pages_used`<4;
  - on the last tile, `frame_done` and `busy`=0 at d+1.
- `next_page` at n: `pages_used` updated at n+1. If `pages_used` was 4 in REQ, `xfer_want` rises at n+1.

## Test plan
- Frame of 2x2 tiles; sequencer grants and completes in 3 cycles; reader returns `next_page` 2 cycles after each `page_ready` -> 4 `page_ready` pulses; `wr_page` 0,1,2,3 then 0; tiles (0,0),(1,0),(0,1),(1,1); one `frame_done`; `pages_used` ends at 0.
- Frame of 6x1 tiles, no `next_page` -> exactly 4 grants; `xfer_want`=0 with `pages_used`=4. One `next_page` -> `pages_used`=3 and `xfer_want`=1 the next cycle, `tile_x`=4.
- `pages_used`=3 in REQ, `xfer_grant` and `next_page` in the same cycle -> `pages_used` stays 3, state XFER.
- `next_page` in IDLE with `pages_used`=0 -> `underflow_err`=1 and `pages_used`=0. The next `frame_start` -> `underflow_err`=0.
- `frame_en` dropped during XFER, then `xfer_done` -> IDLE, no `page_ready`. A new `frame_start` -> `xfer_reset_page` pulse, `pages_used`=0, `tile_x`=`tile_y`=0.
- `mrst_n` asserted asynchronously in XFER with `pages_used`=2 -> all outputs 0 before the next clock edge; after release, `frame_start` is honoured normally.
